// File: rtl/shift7_rx_if.sv
// Output port bundle for shift7_rx: assembled word plus valid/ready handshake.
// The receiver drives the master side; the downstream consumer uses the slave side.
interface shift7_rx_if #(
    parameter int WIDTH = 7
);
    logic [WIDTH-1:0] dataout;
    logic             dout_valid;
    logic             dout_ready;

    modport master (
        output dataout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dataout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/shift7_rx.sv
// shift7_rx: serial-to-parallel receiver for the LSB-first shift7 stream.
// A sync strobe marks bit 0 of a frame; WIDTH qualified bits (bit_en high)
// complete a word, which is offered on a valid/ready port. A word that
// completes while the output slot is still occupied is dropped and the
// sticky overrun flag is raised. A sync in mid-frame restarts the frame.
module shift7_rx #(
    parameter int WIDTH = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync,
    input  logic              bit_en,
    input  logic              datain,
    shift7_rx_if.master       out_if,
    output logic              busy,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shreg_r, shreg_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] dataout_r, dataout_s;
    logic             valid_r, valid_s;
    logic             overrun_r, overrun_s;
    logic [WIDTH-1:0] word_s;
    logic             complete_s;
    logic             slot_free_s;

    // Next-state, shift register, counter and output-slot logic.
    always_comb begin
        state_s     = state_r;
        shreg_s     = shreg_r;
        cnt_s       = cnt_r;
        dataout_s   = dataout_r;
        valid_s     = valid_r;
        overrun_s   = overrun_r;
        complete_s  = 1'b0;
        // New bit enters at the top, so the first bit of a frame ends up at bit 0.
        word_s      = {datain, shreg_r[WIDTH-1:1]};
        slot_free_s = (!valid_r) || out_if.dout_ready;

        case (state_r)
            IDLE: begin
                if (bit_en && sync) begin
                    shreg_s = {datain, {(WIDTH-1){1'b0}}};
                    cnt_s   = CNT_ONE;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (bit_en && sync) begin
                    // Resync: drop the partial word and restart at bit 0.
                    shreg_s = {datain, {(WIDTH-1){1'b0}}};
                    cnt_s   = CNT_ONE;
                    state_s = SHIFT;
                end else if (bit_en) begin
                    shreg_s = word_s;
                    if (cnt_r == CNT_LAST) begin
                        cnt_s      = CNT_ZERO;
                        state_s    = IDLE;
                        complete_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    // Gap in the bit stream: hold everything, no timeout.
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase

        // A transfer empties the slot unless a new word refills it below.
        if (valid_r && out_if.dout_ready) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end

        // Clear first so a simultaneous drop (set) takes priority.
        if (ovr_clr) begin
            overrun_s = 1'b0;
        end else begin
            overrun_s = overrun_r;
        end

        if (complete_s) begin
            if (slot_free_s) begin
                dataout_s = word_s;
                valid_s   = 1'b1;
            end else begin
                overrun_s = 1'b1;
            end
        end else begin
            dataout_s = dataout_r;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            shreg_r   <= {WIDTH{1'b0}};
            cnt_r     <= CNT_ZERO;
            dataout_r <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            shreg_r   <= shreg_s;
            cnt_r     <= cnt_s;
            dataout_r <= dataout_s;
            valid_r   <= valid_s;
            overrun_r <= overrun_s;
        end
    end

    assign out_if.dataout    = dataout_r;
    assign out_if.dout_valid = valid_r;
    assign busy              = (state_r == SHIFT);
    assign overrun           = overrun_r;

endmodule
